ysyx_23060136_exu_scoreboard: RTL

YSYX_23060136_EXU_SCOREBOARD -- requirements
Module: ysyx_23060136_EXU_SCOREBOARD

---
 rtl/ysyx_23060136_DEFINES.sv | 36 +++
 rtl/ysyx_23060136_exu_scoreboard_match.sv | 46 ++++
 rtl/ysyx_23060136_exu_scoreboard.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ysyx_23060136_DEFINES.sv
// Shared widths, the per-stage scoreboard entry and its update rule.
package ysyx_23060136_DEFINES;

    localparam int GPR_W  = 5;
    localparam int CSR_W  = 12;
    localparam int DATA_W = 32;

    // Destination tags of one in-flight instruction held by the scoreboard.
    typedef struct packed {
        logic             valid;
        logic [GPR_W-1:0] rd;
        logic             rd_wen;
        logic [CSR_W-1:0] csr_rd;
        logic             csr_wen;
        logic             is_load;
    } scb_entry_t;

    // Next value of one stage entry: flush beats load, load beats clear, else hold.
    function automatic scb_entry_t scb_next(input scb_entry_t cur,
                                            input scb_entry_t src,
                                            input logic       load,
                                            input logic       clr,
                                            input logic       flush);
        scb_entry_t nxt;
        nxt = cur;
        if (flush) begin
            nxt.valid = 1'b0;
        end else if (load) begin
            nxt = src;
        end else if (clr) begin
            nxt.valid = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ysyx_23060136_exu_scoreboard_match.sv
// Priority match of one EXU1 source against the three producer stages.
module ysyx_23060136_EXU_SCB_MATCH
    import ysyx_23060136_DEFINES::*;
#(
    parameter int TAG_W        = 5,
    parameter bit ZERO_IS_NULL = 1'b1
) (
    input  logic              req_valid,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [2:0]        prod_wen,
    input  logic [TAG_W-1:0]  s1_tag,
    input  logic [TAG_W-1:0]  s2_tag,
    input  logic [TAG_W-1:0]  s3_tag,
    input  logic [DATA_W-1:0] s1_data,
    input  logic [DATA_W-1:0] s2_data,
    input  logic [DATA_W-1:0] s3_data,
    input  logic [1:0]        not_ready,
    output logic              hazard,
    output logic [DATA_W-1:0] data,
    output logic              stall
);

    logic       req_ok;
    logic [2:0] hit;

    // Youngest producer wins; x0 never matches for GPR sources.
    always_comb begin
        req_ok = req_valid && (!ZERO_IS_NULL || (req_tag != '0));
        hit[0] = req_ok && prod_wen[0] && (s1_tag == req_tag);
        hit[1] = req_ok && prod_wen[1] && (s2_tag == req_tag);
        hit[2] = req_ok && prod_wen[2] && (s3_tag == req_tag);
        hazard = |hit;
        data   = '0;
        stall  = 1'b0;
        if (hit[0]) begin
            data  = s1_data;
            stall = not_ready[0];
        end else if (hit[1]) begin
            data  = s2_data;
            stall = not_ready[1];
        end else if (hit[2]) begin
            data  = s3_data;
        end
    end

endmodule

// File: rtl/ysyx_23060136_exu_scoreboard.sv
// EXU1 operand scoreboard: tracks S1..S3 destinations, forwards data, stalls on loads.
module ysyx_23060136_exu_scoreboard
    import ysyx_23060136_DEFINES::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              EXU1_valid,
    input  logic              EXU1_fire,
    input  logic [GPR_W-1:0]  EXU1_rs1,
    input  logic [GPR_W-1:0]  EXU1_rs2,
    input  logic [CSR_W-1:0]  EXU1_csr_rs,
    input  logic              EXU1_rs1_used,
    input  logic              EXU1_rs2_used,
    input  logic              EXU1_csr_used,
    input  logic [GPR_W-1:0]  EXU1_rd,
    input  logic              EXU1_rd_wen,
    input  logic [CSR_W-1:0]  EXU1_csr_rd,
    input  logic              EXU1_csr_wen,
    input  logic              EXU1_is_load,
    input  logic              S1_fire,
    input  logic              S2_fire,
    input  logic              S3_fire,
    input  logic [DATA_W-1:0] S1_rd_data,
    input  logic [DATA_W-1:0] S2_rd_data,
    input  logic [DATA_W-1:0] S3_rd_data,
    input  logic [DATA_W-1:0] S1_csr_data,
    input  logic [DATA_W-1:0] S2_csr_data,
    input  logic [DATA_W-1:0] S3_csr_data,
    input  logic              S2_data_ok,
    input  logic              PIPE_flush,
    output logic              FORWARD_rs1_hazard_EXU1,
    output logic              FORWARD_rs2_hazard_EXU1,
    output logic              FORWARD_csr_rs_hazard_EXU1,
    output logic [DATA_W-1:0] FORWARD_rs1_data_EXU1,
    output logic [DATA_W-1:0] FORWARD_rs2_data_EXU1,
    output logic [DATA_W-1:0] FORWARD_csr_rs_data_EXU1,
    output logic              FORWARD_stall_EXU1,
    output logic [31:0]       FORWARD_stall_cnt
);

    scb_entry_t  s1_q, s2_q, s3_q;
    scb_entry_t  s1_d, s2_d, s3_d;
    scb_entry_t  exu1_e;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [2:0]  gpr_wen, csr_wen;
    logic [1:0]  gpr_not_ready;
    logic        rs1_stall, rs2_stall, csr_stall;

    // Producer qualifiers: a load in S1 never has data, in S2 only once MEM returns it.
    always_comb begin
        gpr_wen       = {s3_q.valid && s3_q.rd_wen,  s2_q.valid && s2_q.rd_wen,  s1_q.valid && s1_q.rd_wen};
        csr_wen       = {s3_q.valid && s3_q.csr_wen, s2_q.valid && s2_q.csr_wen, s1_q.valid && s1_q.csr_wen};
        gpr_not_ready = {s2_q.is_load && !S2_data_ok, s1_q.is_load};
    end

    ysyx_23060136_EXU_SCB_MATCH #(.TAG_W(GPR_W), .ZERO_IS_NULL(1'b1)) u_match_rs1 (
        .req_valid (EXU1_valid && EXU1_rs1_used),
        .req_tag   (EXU1_rs1),
        .prod_wen  (gpr_wen),
        .s1_tag    (s1_q.rd),
        .s2_tag    (s2_q.rd),
        .s3_tag    (s3_q.rd),
        .s1_data   (S1_rd_data),
        .s2_data   (S2_rd_data),
        .s3_data   (S3_rd_data),
        .not_ready (gpr_not_ready),
        .hazard    (FORWARD_rs1_hazard_EXU1),
        .data      (FORWARD_rs1_data_EXU1),
        .stall     (rs1_stall)
    );

    ysyx_23060136_EXU_SCB_MATCH #(.TAG_W(GPR_W), .ZERO_IS_NULL(1'b1)) u_match_rs2 (
        .req_valid (EXU1_valid && EXU1_rs2_used),
        .req_tag   (EXU1_rs2),
        .prod_wen  (gpr_wen),
        .s1_tag    (s1_q.rd),
        .s2_tag    (s2_q.rd),
        .s3_tag    (s3_q.rd),
        .s1_data   (S1_rd_data),
        .s2_data   (S2_rd_data),
        .s3_data   (S3_rd_data),
        .not_ready (gpr_not_ready),
        .hazard    (FORWARD_rs2_hazard_EXU1),
        .data      (FORWARD_rs2_data_EXU1),
        .stall     (rs2_stall)
    );

    // CSR results exist from S1 onward, so this source is always ready.
    ysyx_23060136_EXU_SCB_MATCH #(.TAG_W(CSR_W), .ZERO_IS_NULL(1'b0)) u_match_csr (
        .req_valid (EXU1_valid && EXU1_csr_used),
        .req_tag   (EXU1_csr_rs),
        .prod_wen  (csr_wen),
        .s1_tag    (s1_q.csr_rd),
        .s2_tag    (s2_q.csr_rd),
        .s3_tag    (s3_q.csr_rd),
        .s1_data   (S1_csr_data),
        .s2_data   (S2_csr_data),
        .s3_data   (S3_csr_data),
        .not_ready (2'b00),
        .hazard    (FORWARD_csr_rs_hazard_EXU1),
        .data      (FORWARD_csr_rs_data_EXU1),
        .stall     (csr_stall)
    );

    // Entry advance, stall generation and saturating stall counter.
    always_comb begin
        FORWARD_stall_EXU1 = rs1_stall || rs2_stall || csr_stall;
        exu1_e.valid   = 1'b1;
        exu1_e.rd      = EXU1_rd;
        exu1_e.rd_wen  = EXU1_rd_wen;
        exu1_e.csr_rd  = EXU1_csr_rd;
        exu1_e.csr_wen = EXU1_csr_wen;
        exu1_e.is_load = EXU1_is_load;
        s1_d = scb_next(s1_q, exu1_e, EXU1_fire && !FORWARD_stall_EXU1, S1_fire, PIPE_flush);
        s2_d = scb_next(s2_q, s1_q,   S1_fire, S2_fire, PIPE_flush);
        s3_d = scb_next(s3_q, s2_q,   S2_fire, S3_fire, PIPE_flush);
        stall_cnt_d = stall_cnt_q;
        if (FORWARD_stall_EXU1 && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        FORWARD_stall_cnt = stall_cnt_q;
    end

    // State registers; reset clears only valid bits and the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q.valid  <= 1'b0;
            s2_q.valid  <= 1'b0;
            s3_q.valid  <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Advancing into an occupied stage that is not itself advancing drops an instruction.
    a_s2_overrun: assert property (@(posedge clk) disable iff (rst || PIPE_flush)
        !(S1_fire && s2_q.valid && !S2_fire));
    a_s3_overrun: assert property (@(posedge clk) disable iff (rst || PIPE_flush)
        !(S2_fire && s3_q.valid && !S3_fire));
    // A load always writes a GPR by the time it reaches writeback.
    a_s3_load_wen: assert property (@(posedge clk) disable iff (rst)
        !(s3_q.valid && s3_q.is_load && !s3_q.rd_wen));

endmodule
